// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute control FSM for the
// 16-bit processor. It fetches over a req/ack handshake, decodes the
// instruction register, strobes the regfile/ALU controls for one cycle in
// EXECUTE, and resolves JMP/JZ branches when it updates the PC.
module instr_sequencer #(
    parameter int PC_WIDTH = 8
) (
    input  logic                clk_pi,
    input  logic                reset_n_pi,
    input  logic                run_pi,
    output logic                imem_req_po,
    output logic [PC_WIDTH-1:0] imem_addr_po,
    input  logic                imem_ack_pi,
    input  logic [15:0]         imem_data_pi,
    input  logic [15:0]         reg1_data_pi,
    output logic [2:0]          src1_po,
    output logic [2:0]          src2_po,
    output logic [2:0]          dest_po,
    output logic [7:0]          imm_po,
    output logic [3:0]          alu_op_po,
    output logic                wr_dest_po,
    output logic                movi_lower_po,
    output logic                movi_higher_po,
    output logic                regfile_clk_en_po,
    output logic                flag_hold_po,
    output logic [PC_WIDTH-1:0] pc_po,
    output logic                halted_po
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_MOVIL = 4'hA;
    localparam logic [3:0] OP_MOVIH = 4'hB;
    localparam logic [3:0] OP_JZ    = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t                state_q;
    state_t                state_d;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   pc_d;
    logic [15:0]           ir_q;
    logic [15:0]           ir_d;

    logic [3:0]            opcode_s;
    logic                  is_alu_s;
    logic                  jump_taken_s;

    assign opcode_s     = ir_q[15:12];
    assign is_alu_s     = (opcode_s >= 4'h1) && (opcode_s <= 4'h9);
    // JZ tests the register selected by rd, which arrives on read port 1
    assign jump_taken_s = (opcode_s == OP_JMP) ||
                          ((opcode_s == OP_JZ) && (reg1_data_pi == 16'h0000));

    // State register; asynchronous reset returns to IDLE
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC and instruction register
    always_ff @(posedge clk_pi or negedge reset_n_pi) begin
        if (!reset_n_pi) begin
            pc_q <= {PC_WIDTH{1'b0}};
            ir_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // Next-state logic; a running instruction always completes even if run drops
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_pi) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack_pi) begin
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (opcode_s == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (run_pi) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // IR capture on the ack in FETCH and PC update on leaving EXECUTE
    always_comb begin
        ir_d = ir_q;
        pc_d = pc_q;
        if ((state_q == ST_FETCH) && imem_ack_pi) begin
            ir_d = imem_data_pi;
        end else begin
            ir_d = ir_q;
        end
        if ((state_q == ST_EXECUTE) && (opcode_s != OP_HALT)) begin
            if (jump_taken_s) begin
                pc_d = ir_q[PC_WIDTH-1:0];
            end else begin
                pc_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // Output logic: fetch handshake, decoded fields and one-cycle EXECUTE strobes
    always_comb begin
        imem_req_po       = 1'b0;
        wr_dest_po        = 1'b0;
        movi_lower_po     = 1'b0;
        movi_higher_po    = 1'b0;
        regfile_clk_en_po = 1'b0;
        flag_hold_po      = 1'b0;
        halted_po         = 1'b0;
        imem_addr_po      = pc_q;
        pc_po             = pc_q;
        src1_po           = (opcode_s == OP_JZ) ? ir_q[11:9] : ir_q[8:6];
        src2_po           = ir_q[5:3];
        dest_po           = ir_q[11:9];
        imm_po            = ir_q[7:0];
        alu_op_po         = is_alu_s ? opcode_s : 4'h0;
        case (state_q)
            ST_FETCH: begin
                imem_req_po = 1'b1;
            end
            ST_EXECUTE: begin
                if (is_alu_s) begin
                    wr_dest_po        = 1'b1;
                    regfile_clk_en_po = 1'b1;
                end else begin
                    case (opcode_s)
                        OP_MOVIL: begin
                            wr_dest_po        = 1'b1;
                            movi_lower_po     = 1'b1;
                            regfile_clk_en_po = 1'b1;
                            flag_hold_po      = 1'b1;
                        end
                        OP_MOVIH: begin
                            wr_dest_po        = 1'b1;
                            movi_higher_po    = 1'b1;
                            regfile_clk_en_po = 1'b1;
                            flag_hold_po      = 1'b1;
                        end
                        default: begin
                            wr_dest_po = 1'b0;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                halted_po = 1'b1;
            end
            default: begin
                imem_req_po = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed program from the test plan, then a
// randomized program, checked instruction by instruction against a model
// that tracks only the architectural PC, IR and halt status.
module tb_instr_sequencer;

    localparam int PW = 8;

    logic          clk_pi = 1'b0;
    logic          reset_n_pi;
    logic          run_pi;
    logic          imem_req_po;
    logic [PW-1:0] imem_addr_po;
    logic          imem_ack_pi;
    logic [15:0]   imem_data_pi;
    logic [15:0]   reg1_data_pi;
    logic [2:0]    src1_po, src2_po, dest_po;
    logic [7:0]    imm_po;
    logic [3:0]    alu_op_po;
    logic          wr_dest_po, movi_lower_po, movi_higher_po;
    logic          regfile_clk_en_po, flag_hold_po;
    logic [PW-1:0] pc_po;
    logic          halted_po;

    logic [4:0]    strobes;
    assign strobes = {wr_dest_po, movi_lower_po, movi_higher_po, regfile_clk_en_po, flag_hold_po};

    instr_sequencer #(.PC_WIDTH(PW)) dut (
        .clk_pi(clk_pi), .reset_n_pi(reset_n_pi), .run_pi(run_pi),
        .imem_req_po(imem_req_po), .imem_addr_po(imem_addr_po),
        .imem_ack_pi(imem_ack_pi), .imem_data_pi(imem_data_pi),
        .reg1_data_pi(reg1_data_pi),
        .src1_po(src1_po), .src2_po(src2_po), .dest_po(dest_po),
        .imm_po(imm_po), .alu_op_po(alu_op_po),
        .wr_dest_po(wr_dest_po), .movi_lower_po(movi_lower_po),
        .movi_higher_po(movi_higher_po), .regfile_clk_en_po(regfile_clk_en_po),
        .flag_hold_po(flag_hold_po), .pc_po(pc_po), .halted_po(halted_po)
    );

    always #5 clk_pi = ~clk_pi;

    // reference state: instruction memory and architectural registers
    logic [15:0]   mem [256];
    logic [PW-1:0] m_pc;
    logic [15:0]   m_ir;
    logic          m_halt;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe set {wr_dest, movi_lower, movi_higher, clk_en, flag_hold} per opcode
    function automatic logic [4:0] exp_strobes(input logic [3:0] op);
        if (op >= 4'h1 && op <= 4'h9) return 5'b10010;
        else if (op == 4'hA)          return 5'b11011;
        else if (op == 4'hB)          return 5'b10111;
        else                          return 5'b00000;
    endfunction

    task automatic chk_dec(input string ph, input logic [15:0] ir);
        logic [3:0] op;
        op = ir[15:12];
        chk({ph, "_src1"}, src1_po, (op == 4'hC) ? ir[11:9] : ir[8:6]);
        chk({ph, "_src2"}, src2_po, ir[5:3]);
        chk({ph, "_dest"}, dest_po, ir[11:9]);
        chk({ph, "_imm"},  imm_po,  ir[7:0]);
        chk({ph, "_alu"},  alu_op_po, (op >= 4'h1 && op <= 4'h9) ? op : 4'h0);
    endtask

    task automatic cyc();
        @(posedge clk_pi);
        @(negedge clk_pi);
    endtask

    // from IDLE: raise run and step into the fetch of the instruction at m_pc
    task automatic start_run();
        run_pi = 1'b1;
        cyc();
    endtask

    // one full instruction starting at a negedge inside FETCH
    task automatic do_instr(input int waits, input logic [15:0] r1, input logic run_after, input logic spur);
        logic [3:0] op;
        for (int w = 0; w <= waits; w++) begin
            chk("fetch_req",  imem_req_po, 1'b1);
            chk("fetch_addr", imem_addr_po, m_pc);
            chk("fetch_strb", strobes, 5'b00000);
            chk_dec("fetch", m_ir);
            if (w == waits) begin
                imem_ack_pi  = 1'b1;
                imem_data_pi = mem[m_pc];
            end else begin
                imem_ack_pi  = 1'b0;
                imem_data_pi = 16'($urandom);
            end
            cyc();
        end
        m_ir = mem[m_pc];
        op   = m_ir[15:12];
        imem_ack_pi  = spur;
        imem_data_pi = 16'($urandom);
        reg1_data_pi = r1;
        run_pi       = run_after;
        chk("dec_req",  imem_req_po, 1'b0);
        chk("dec_strb", strobes, 5'b00000);
        chk_dec("decode", m_ir);
        cyc();
        imem_ack_pi = 1'b0;
        chk("exe_req",  imem_req_po, 1'b0);
        chk("exe_strb", strobes, exp_strobes(op));
        chk("exe_pc",   pc_po, m_pc);
        chk_dec("exec", m_ir);
        cyc();
        if (op == 4'hF) begin
            m_halt = 1'b1;
        end else if (op == 4'hD || (op == 4'hC && r1 == 16'h0000)) begin
            m_pc = m_ir[PW-1:0];
        end else begin
            m_pc = m_pc + 1'b1;
        end
        chk("post_pc",     pc_po, m_pc);
        chk("post_halted", halted_po, m_halt);
        chk("post_req",    imem_req_po, (!m_halt) && run_after);
        chk("post_strb",   strobes, 5'b00000);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  imem_req_po, 1'b0);
        chk({tag, "_addr"}, imem_addr_po, 0);
        chk({tag, "_pc"},   pc_po, 0);
        chk({tag, "_halt"}, halted_po, 1'b0);
        chk({tag, "_strb"}, strobes, 5'b00000);
        chk_dec(tag, 16'h0000);
    endtask

    initial begin
        reset_n_pi   = 1'b0;
        run_pi       = 1'b0;
        imem_ack_pi  = 1'b0;
        imem_data_pi = 16'h0000;
        reg1_data_pi = 16'h0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1450;   // ADD r2, r1, r2
        mem[8'h01] = 16'hA65A;   // MOVIL r3, 0x5A
        mem[8'h02] = 16'hB6C3;   // MOVIH r3, 0xC3
        mem[8'h03] = 16'hC810;   // JZ r4, 0x10 (taken)
        mem[8'h10] = 16'hC820;   // JZ r4, 0x20 (not taken)
        mem[8'h11] = 16'hD0FF;   // JMP 0xFF
        mem[8'hFF] = 16'h0000;   // NOP, wraps PC to 0
        m_pc = '0; m_ir = 16'h0000; m_halt = 1'b0;

        repeat (3) @(negedge clk_pi);
        chk_all_zero("reset");
        reset_n_pi = 1'b1;
        start_run();

        do_instr(0, 16'h1234, 1'b1, 1'b0);   // ADD
        do_instr(0, 16'h1234, 1'b1, 1'b0);   // MOVIL
        do_instr(0, 16'h1234, 1'b1, 1'b0);   // MOVIH
        do_instr(0, 16'h0000, 1'b1, 1'b0);   // JZ taken
        do_instr(0, 16'h0001, 1'b1, 1'b0);   // JZ not taken
        do_instr(0, 16'h0000, 1'b1, 1'b0);   // JMP 0xFF
        do_instr(0, 16'h0000, 1'b1, 1'b0);   // NOP wrap
        do_instr(3, 16'h0000, 1'b0, 1'b1);   // ADD with ack delay, run drops

        for (int k = 0; k < 2; k++) begin
            imem_ack_pi = 1'b1;
            cyc();
            chk("idle_req", imem_req_po, 1'b0);
            chk("idle_pc",  pc_po, m_pc);
        end
        imem_ack_pi = 1'b0;

        mem[8'h01] = 16'hF000;               // HALT
        start_run();
        do_instr(0, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("halt_req", imem_req_po, 1'b0);
            chk("halt_flag", halted_po, 1'b1);
            chk("halt_pc",  pc_po, m_pc);
        end

        // reset while halted, restart, then reset mid-fetch
        reset_n_pi = 1'b0;
        #1;
        chk("rst_halt_flag", halted_po, 1'b0);
        @(negedge clk_pi);
        reset_n_pi = 1'b1;
        m_pc = '0; m_ir = 16'h0000; m_halt = 1'b0;
        start_run();
        chk("refetch_req",  imem_req_po, 1'b1);
        chk("refetch_addr", imem_addr_po, 0);
        reset_n_pi = 1'b0;
        #1;
        chk_all_zero("rst_fetch");
        run_pi = 1'b0;
        @(negedge clk_pi);
        reset_n_pi = 1'b1;
        cyc();
        chk("post_rst_req", imem_req_po, 1'b0);
        chk("post_rst_pc",  pc_po, 0);

        // randomized program, no HALT
        for (int i = 0; i < 256; i++) begin
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        end
        start_run();
        for (int n = 0; n < 80; n++) begin
            logic [15:0] r1;
            logic        ra;
            r1 = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            ra = ($urandom_range(0, 4) != 0);
            do_instr($urandom_range(0, 3), r1, ra, 1'($urandom_range(0, 1)));
            if (!ra) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    imem_ack_pi = 1'($urandom_range(0, 1));
                    cyc();
                    chk("rnd_idle_req", imem_req_po, 1'b0);
                    chk("rnd_idle_pc",  pc_po, m_pc);
                end
                imem_ack_pi = 1'b0;
                start_run();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
